// File: rtl/i2c_cfg_pkg.sv
// Shared state encoding, table markers and sizing helper for the I2C configuration sequencer.
// Latency: n/a (declarations only); backpressure: n/a.
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        POWER_WAIT,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_DONE,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0]  DELAY_MARKER = 8'hFF;
    localparam logic [15:0] END_MARKER   = 16'hFEFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Request/response bus between the configuration sequencer and the I2C byte engine.
// Latency: wires only; backpressure: engine holds i2cBusy high to defer the next i2cStart.
interface i2c_config_sequencer_if;
    logic [23:0] i2cData;
    logic        i2cStart;
    logic        i2cBusy;
    logic        i2cDone;
    logic        i2cNack;

    modport master (output i2cData, i2cStart, input i2cBusy, i2cDone, i2cNack);
    modport slave  (input i2cData, i2cStart, output i2cBusy, i2cDone, i2cNack);
endinterface

// File: rtl/i2c_config_sequencer_cycle_timer.sv
// Down-counter: after a start pulse with load N, expired pulses in the Nth cycle (first cycle if N is 0 or 1).
// Latency: N cycles from start; backpressure: none, a new start simply reloads.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;
    logic             running;

    assign expired = running && (cnt <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= load;
            running <= 1'b1;
        end else if (running) begin
            if (expired) begin
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a register table after power-up, issuing one I2C write per entry with NACK retries, delays and end marker.
// Latency: POWERUP_CYCLES + 3 cycles to first i2cStart; backpressure: waits in ISSUE while i2cBusy is high.
module i2c_config_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR     = 8'h72,
    parameter int unsigned NUM_ENTRIES    = 32,
    parameter int unsigned POWERUP_CYCLES = 10_000_000,
    parameter int unsigned RETRY_LIMIT    = 3,
    parameter int unsigned MS_CYCLES      = 50_000
) (
    input  logic                          clock50M,
    input  logic                          reset,
    input  logic                          configStart,
    output logic [7:0]                    romAddr,
    input  logic [15:0]                   romData,
    i2c_config_sequencer_if.master        i2c,
    output logic                          configBusy,
    output logic                          configDone,
    output logic                          configError,
    output logic [7:0]                    failIndex
);

    // One timer serves both waits, so it is sized for the longer of the two.
    localparam int unsigned TMR_MAX = max_u(POWERUP_CYCLES, 255 * MS_CYCLES);
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

    localparam logic [7:0] LAST_ADDR = 8'(NUM_ENTRIES - 1);
    localparam logic [7:0] RETRY_MAX = 8'(RETRY_LIMIT);

    state_t          state_q, state_d;
    logic [7:0]      rom_addr_q, rom_addr_d;
    logic [23:0]     dat_q, dat_d;
    logic            start_q, start_d;
    logic [7:0]      retry_q, retry_d;
    logic [7:0]      fail_q, fail_d;
    logic            tmr_start;
    logic [TMR_W-1:0] tmr_load;
    logic            tmr_expired;
    logic [TMR_W-1:0] pow_load;
    logic [TMR_W-1:0] dly_load;

    assign pow_load = TMR_W'(POWERUP_CYCLES);
    assign dly_load = TMR_W'(romData[7:0]) * TMR_W'(MS_CYCLES);

    cycle_timer #(.WIDTH(TMR_W)) u_timer (
        .clk     (clock50M),
        .reset   (reset),
        .start   (tmr_start),
        .load    (tmr_load),
        .expired (tmr_expired)
    );

    always_ff @(posedge clock50M) begin
        if (reset) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            dat_q      <= '0;
            start_q    <= 1'b0;
            retry_q    <= '0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            dat_q      <= dat_d;
            start_q    <= start_d;
            retry_q    <= retry_d;
            fail_q     <= fail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        dat_d      = dat_q;
        start_d    = 1'b0;
        retry_d    = retry_q;
        fail_d     = fail_q;
        tmr_start  = 1'b0;
        tmr_load   = '0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (configStart) begin
                    state_d    = POWER_WAIT;
                    rom_addr_d = '0;
                    retry_d    = '0;
                    fail_d     = '0;
                    tmr_start  = 1'b1;
                    tmr_load   = pow_load;
                end
            end
            POWER_WAIT: if (tmr_expired) state_d = FETCH;
            FETCH:      state_d = LATCH;
            LATCH: begin
                if (romData == END_MARKER) begin
                    state_d = DONE;
                end else if (romData[15:8] == DELAY_MARKER) begin
                    if (romData[7:0] == 8'd0) begin
                        state_d = NEXT;
                    end else begin
                        state_d   = DELAY;
                        tmr_start = 1'b1;
                        tmr_load  = dly_load;
                    end
                end else begin
                    state_d = ISSUE;
                    dat_d   = {SLAVE_ADDR, romData};
                end
            end
            ISSUE: begin
                if (!i2c.i2cBusy) begin
                    start_d = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i2c.i2cDone) begin
                    if (!i2c.i2cNack) begin
                        retry_d = '0;
                        state_d = NEXT;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ISSUE;
                    end else begin
                        fail_d  = rom_addr_q;
                        state_d = ERROR;
                    end
                end
            end
            DELAY: if (tmr_expired) state_d = NEXT;
            NEXT: begin
                // The last index terminates the run instead of wrapping back to 0.
                if (rom_addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign romAddr      = rom_addr_q;
    assign i2c.i2cData  = dat_q;
    assign i2c.i2cStart = start_q;
    assign failIndex    = fail_q;
    assign configBusy   = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign configDone   = (state_q == DONE);
    assign configError  = (state_q == ERROR);

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: ROM and I2C engine models plus a transaction-level expectation model.
module tb_i2c_config_sequencer;

    localparam int unsigned N  = 3;
    localparam int unsigned PU = 10;
    localparam int unsigned RL = 3;
    localparam int unsigned MS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic config_start = 1'b0;
    logic force_busy = 1'b0;
    logic eng_clr = 1'b0;

    logic [7:0]  rom_addr;
    logic [7:0]  fail_index;
    logic [15:0] rom_q;
    logic        cfg_busy, cfg_done, cfg_err;

    always #5 clk = ~clk;

    i2c_config_sequencer_if bus();

    i2c_config_sequencer #(
        .SLAVE_ADDR     (8'h72),
        .NUM_ENTRIES    (N),
        .POWERUP_CYCLES (PU),
        .RETRY_LIMIT    (RL),
        .MS_CYCLES      (MS)
    ) dut (
        .clock50M    (clk),
        .reset       (reset),
        .configStart (config_start),
        .romAddr     (rom_addr),
        .romData     (rom_q),
        .i2c         (bus),
        .configBusy  (cfg_busy),
        .configDone  (cfg_done),
        .configError (cfg_err),
        .failIndex   (fail_index)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [0:255];
    int          nack_plan [0:255];
    int          attempts [0:255];

    logic        eng_busy, eng_done, eng_nack;
    int          eng_left;
    logic [7:0]  eng_idx;
    int          n_starts, bad_start, unstable;
    logic [23:0] log_dat [0:63];
    logic [23:0] cur_dat;

    assign bus.i2cBusy = force_busy | eng_busy;
    assign bus.i2cDone = eng_done;
    assign bus.i2cNack = eng_nack;

    // ROM answers one cycle after the address changes.
    always @(posedge clk) rom_q <= rom[rom_addr];

    // Engine: busy from the cycle after i2cStart, done/nack pulse after 1..4 busy cycles.
    always @(posedge clk) begin
        if (reset || eng_clr) begin
            eng_busy  <= 1'b0;
            eng_done  <= 1'b0;
            eng_nack  <= 1'b0;
            eng_left  <= 0;
            eng_idx   <= 8'd0;
            n_starts  <= 0;
            bad_start <= 0;
            unstable  <= 0;
            cur_dat   <= 24'd0;
            for (int i = 0; i < 256; i++) attempts[i] <= 0;
        end else begin
            eng_done <= 1'b0;
            eng_nack <= 1'b0;
            if (bus.i2cStart) begin
                if (bus.i2cBusy) bad_start <= bad_start + 1;
                if (n_starts < 64) log_dat[n_starts] <= bus.i2cData;
                n_starts <= n_starts + 1;
                cur_dat  <= bus.i2cData;
            end
            if (bus.i2cStart && !eng_busy) begin
                eng_busy <= 1'b1;
                eng_left <= int'($urandom_range(1, 4));
                eng_idx  <= rom_addr;
            end else if (eng_busy) begin
                if (eng_left <= 1) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                    eng_nack <= (attempts[eng_idx] < nack_plan[eng_idx]);
                    attempts[eng_idx] <= attempts[eng_idx] + 1;
                end else begin
                    eng_left <= eng_left - 1;
                end
            end
            if (eng_done && (bus.i2cData !== cur_dat)) unstable <= unstable + 1;
        end
    end

    logic [23:0] exp_dat [0:63];
    int          exp_n;
    logic        exp_done, exp_err;
    logic [7:0]  exp_fail, exp_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected transfer list and outcome derived straight from the table rules.
    task automatic model();
        int tries;
        exp_n    = 0;
        exp_done = 1'b1;
        exp_err  = 1'b0;
        exp_fail = 8'd0;
        exp_last = 8'(N - 1);
        for (int i = 0; i < int'(N); i++) begin
            if (rom[i] == 16'hFEFF) begin
                exp_last = 8'(i);
                break;
            end
            if (rom[i][15:8] == 8'hFF) continue;
            tries = (nack_plan[i] > int'(RL)) ? int'(RL) + 1 : nack_plan[i] + 1;
            for (int k = 0; k < tries; k++) begin
                exp_dat[exp_n] = {8'h72, rom[i]};
                exp_n++;
            end
            if (nack_plan[i] > int'(RL)) begin
                exp_done = 1'b0;
                exp_err  = 1'b1;
                exp_fail = 8'(i);
                exp_last = 8'(i);
                break;
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rom_addr"},  32'(rom_addr), 32'd0);
        chk({tag, "_i2c_data"},  32'(bus.i2cData), 32'd0);
        chk({tag, "_i2c_start"}, 32'(bus.i2cStart), 32'd0);
        chk({tag, "_busy"},      32'(cfg_busy), 32'd0);
        chk({tag, "_done"},      32'(cfg_done), 32'd0);
        chk({tag, "_error"},     32'(cfg_err), 32'd0);
        chk({tag, "_fail_idx"},  32'(fail_index), 32'd0);
    endtask

    task automatic run(input int poke_after, input int hold_busy, output int cycles);
        bit poked = 1'b0;
        int first = -1;
        model();
        @(negedge clk); eng_clr = 1'b1;
        @(negedge clk); eng_clr = 1'b0;
        if (hold_busy > 0) force_busy = 1'b1;
        config_start = 1'b1;
        @(negedge clk); config_start = 1'b0;
        chk("busy_next_cycle", 32'(cfg_busy), 32'd1);
        chk("done_cleared", 32'(cfg_done), 32'd0);
        chk("error_cleared", 32'(cfg_err), 32'd0);
        cycles = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            config_start = 1'b0;
            if (first < 0 && n_starts > 0) first = c;
            if (hold_busy > 0 && c == hold_busy + 1)
                chk("start_after_busy_fall", 32'(bus.i2cStart), 32'd1);
            if (hold_busy > 0 && c == hold_busy) force_busy = 1'b0;
            if (cfg_done || cfg_err) begin
                cycles = c;
                break;
            end
            if (poke_after > 0 && !poked && n_starts >= poke_after) begin
                config_start = 1'b1;
                poked = 1'b1;
            end
        end
        force_busy = 1'b0;
        chk("run_terminated", 32'(cycles >= 0), 32'd1);
        chk("config_done", 32'(cfg_done), 32'(exp_done));
        chk("config_error", 32'(cfg_err), 32'(exp_err));
        chk("busy_low_at_end", 32'(cfg_busy), 32'd0);
        if (exp_err) chk("fail_index", 32'(fail_index), 32'(exp_fail));
        chk("rom_addr_final", 32'(rom_addr), 32'(exp_last));
        chk("start_count", 32'(n_starts), 32'(exp_n));
        for (int i = 0; i < exp_n && i < 64; i++)
            chk("start_data", 32'(log_dat[i]), 32'(exp_dat[i]));
        chk("no_start_while_busy", 32'(bad_start), 32'd0);
        chk("data_stable", 32'(unstable), 32'd0);
        if (exp_n > 0) chk("powerup_wait", 32'(first >= int'(PU)), 32'd1);
        repeat (5) @(negedge clk);
        chk("status_held", 32'({cfg_done, cfg_err}), 32'({exp_done, exp_err}));
    endtask

    initial begin
        int cyc_a, cyc_b, dummy;
        bit got;
        for (int i = 0; i < 256; i++) begin
            rom[i]       = 16'h0000;
            nack_plan[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        // Three plain entries, all acknowledged.
        rom[0] = 16'h4110; rom[1] = 16'h2233; rom[2] = 16'h5A01;
        run(0, 0, dummy);
        chk("entry_41_10_data", 32'(log_dat[0]), 32'h0072_4110);

        // Entry 1 NACKs twice then ACKs.
        nack_plan[1] = 2;
        run(0, 0, dummy);

        // Entry 2 never ACKs.
        nack_plan[1] = 0; nack_plan[2] = 9;
        run(0, 0, dummy);
        chk("error_fail_index_2", 32'(fail_index), 32'd2);
        nack_plan[2] = 0;

        // Delay marker of 3 ms versus 0 ms, both followed by the end marker.
        rom[0] = 16'hFF03; rom[1] = 16'hFEFF; rom[2] = 16'h1234;
        run(0, 0, cyc_a);
        rom[0] = 16'hFF00;
        run(0, 0, cyc_b);
        chk("delay_gap", 32'(cyc_a - cyc_b), 32'd12);

        // Reset while a transfer is outstanding, then a full replay.
        rom[0] = 16'h4110; rom[1] = 16'h2233; rom[2] = 16'h5A01;
        @(negedge clk); eng_clr = 1'b1;
        @(negedge clk); eng_clr = 1'b0; config_start = 1'b1;
        @(negedge clk); config_start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (eng_busy) begin
                got = 1'b1;
                break;
            end
        end
        chk("reached_wait_done", 32'(got), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        reset = 1'b0;
        run(0, 0, dummy);

        // Engine busy through power-up and 20+ cycles of ISSUE; a mid-run configStart is ignored.
        run(2, 35, dummy);

        // Randomised tables and NACK patterns.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'(N); i++) begin
                case ($urandom_range(0, 9))
                    0: rom[i] = {8'hFF, 8'($urandom_range(0, 3))};
                    1: rom[i] = 16'hFEFF;
                    default: rom[i] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
                endcase
                nack_plan[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : 0;
            end
            run(0, 0, dummy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 8'h72, 8-bit I2C slave write address placed in i2cData[23:16].
REQ-002 SHALL have parameter NUM_ENTRIES, default 32, number of configuration table entries (2..256).
REQ-003 SHALL have parameter POWERUP_CYCLES, default 10_000_000, clock cycles waited after start before first transfer.
REQ-004 SHALL have parameter RETRY_LIMIT, default 3, retries allowed per entry after a NACK.
REQ-005 SHALL have parameter MS_CYCLES, default 50_000, clock cycles per millisecond for delay entries.
REQ-006 One clock; reset is synchronous and active-high: clock50M  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 configStart  input  1  one-cycle pulse starting a configuration run.
REQ-009 romAddr  output  8  configuration table index.
REQ-010 romData  input  16  table entry: [15:8] register address, [7:0] register data; valid exactly one cycle after romAddr changes.
REQ-011 i2cData  output  24  {SLAVE_ADDR, register address, data} to the I2C byte engine.
REQ-012 i2cStart  output  1  one-cycle transfer request pulse.
REQ-013 i2cBusy  input  1  engine busy; high from cycle after i2cStart until transfer end.
REQ-014 i2cDone  input  1  one-cycle pulse at transfer end.
REQ-015 i2cNack  input  1  valid with i2cDone; 1 = any byte not acknowledged.
REQ-016 configBusy / configDone / configError  output  1 each  run in progress / run completed / run aborted.
REQ-017 failIndex  output  8  table index of the entry that aborted the run.

Function
REQ-018 States SHALL be IDLE, POWER_WAIT, FETCH, LATCH, ISSUE, WAIT_DONE, DELAY, NEXT, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + configStart -> POWER_WAIT; clears configDone, configError, retry count, romAddr=0; configBusy high next cycle.
REQ-020 POWER_WAIT SHALL count exactly POWERUP_CYCLES cycles then -> FETCH; POWERUP_CYCLES=0 -> FETCH next cycle.
REQ-021 FETCH -> LATCH (one-cycle ROM latency); LATCH captures romData.
REQ-022 LATCH: register address 8'hFF is a delay marker -> DELAY for data*MS_CYCLES cycles, then NEXT; data 0 -> NEXT immediately; no I2C transfer issued.
REQ-023 LATCH: register address 8'hFE with data 8'hFF is end-of-table -> DONE, regardless of remaining entries.
REQ-024 Otherwise -> ISSUE; i2cData driven and stable from ISSUE until i2cDone.
REQ-025 ISSUE SHALL pulse i2cStart one cycle only when i2cBusy is low; else wait in ISSUE.
REQ-026 WAIT_DONE on i2cDone: i2cNack=0 -> NEXT, retry count cleared; i2cNack=1 and retries < RETRY_LIMIT -> retry count+1, ISSUE; else -> ERROR.
REQ-027 NEXT: romAddr = NUM_ENTRIES-1 -> DONE; else romAddr+1 -> FETCH. romAddr SHALL never wrap.
REQ-028 DONE: configDone=1, configBusy=0, held until next configStart or reset.
REQ-029 ERROR: configError=1, configBusy=0, failIndex=romAddr, held until next configStart or reset.
REQ-030 configStart while configBusy SHALL be ignored.
REQ-031 i2cDone outside WAIT_DONE SHALL be ignored.
REQ-032 Delay counter width SHALL hold 255*MS_CYCLES without overflow; power-up counter width from POWERUP_CYCLES.

Reset
REQ-033 reset SHALL force IDLE; romAddr=0, i2cData=0, i2cStart=0, configBusy=0, configDone=0, configError=0, failIndex=0, counters 0.
REQ-034 reset mid-transfer SHALL drop i2cStart same edge and issue no further requests; engine reset handled outside.

Structure
REQ-035 State encoding, DELAY_MARKER 8'hFF, END_MARKER 16'hFEFF SHALL live in shared package i2c_cfg_pkg.
REQ-036 One sub-module, cycle_timer (load value, start, expired pulse), SHALL serve POWER_WAIT and DELAY.

Verification
REQ-037 POWERUP_CYCLES=10, 3 entries, all ACK -> configStart, 3 i2cStart pulses, i2cData 24'h72_41_10 for entry {41,10}, configDone=1, romAddr=2.
REQ-038 Entry 1 NACKs twice then ACKs, RETRY_LIMIT=3 -> exactly 3 i2cStart for entry 1, configDone=1.
REQ-039 Entry 2 always NACKs, RETRY_LIMIT=3 -> 4 i2cStart for entry 2, configError=1, failIndex=2, configDone=0.
REQ-040 Entry {FF,03}, MS_CYCLES=4 -> 12-cycle gap, no i2cStart; then {FE,FF} -> DONE with remaining entries unsent.
REQ-041 reset asserted in WAIT_DONE -> next cycle IDLE, all outputs zero; later configStart replays from romAddr 0.
REQ-042 i2cBusy held high 20 cycles in ISSUE -> i2cStart withheld until cycle after i2cBusy falls; configStart during run ignored.
